// File: rtl/udp_send.sv
// UDP transmit framer: prepends the 8-byte UDP header to an application
// payload stream and forwards the datagram byte-wise toward the IP layer.
module udp_send #(
  parameter int MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hdr_valid_in,
  output logic        hdr_ready_out,
  input  logic [15:0] src_port_in,
  input  logic [15:0] dest_port_in,
  input  logic [15:0] payload_len_in,
  input  logic [7:0]  udpdata_tdata_in,
  input  logic        udpdata_tvalid_in,
  input  logic        udpdata_tlast_in,
  output logic        udpdata_tready_out,
  output logic [7:0]  udp_axis_tdata_out,
  output logic        udp_axis_tvalid_out,
  output logic        udp_axis_tlast_out,
  input  logic        udp_axis_tready_in,
  output logic        len_err_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DRAIN
  } state_t;

  state_t      state;
  logic [15:0] src_port;
  logic [15:0] dest_port;
  logic [15:0] payload_len;
  logic [15:0] remaining;
  logic [15:0] udp_len;
  logic [2:0]  hdr_idx;
  logic        last_loaded;
  logic        drain_seen;

  logic hdr_accept;
  logic len_bad;
  logic out_fire;
  logic in_fire;
  logic drain_end;

  assign udp_len   = payload_len + 16'd8;
  assign len_bad   = (payload_len_in == 16'd0) ||
                     (int'(payload_len_in) > MAX_PAYLOAD);
  assign hdr_accept = hdr_valid_in && (state == IDLE);
  assign out_fire  = udp_axis_tvalid_out && udp_axis_tready_in;
  assign in_fire   = udpdata_tvalid_in && udpdata_tready_out;
  assign drain_end = drain_seen || (in_fire && udpdata_tlast_in);

  assign hdr_ready_out = (state == IDLE);
  assign busy_out      = (state != IDLE);

  // last_loaded stops intake once the final byte sits in the output register
  always_comb begin
    udpdata_tready_out = 1'b0;
    unique case (state)
      PAYLOAD:
        udpdata_tready_out = (!udp_axis_tvalid_out || udp_axis_tready_in)
                             && !last_loaded;
      DRAIN:   udpdata_tready_out = !drain_seen;
      default: udpdata_tready_out = 1'b0;
    endcase
  end

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = src_port[15:8];
      3'd1:    b = src_port[7:0];
      3'd2:    b = dest_port[15:8];
      3'd3:    b = dest_port[7:0];
      3'd4:    b = udp_len[15:8];
      3'd5:    b = udp_len[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      src_port            <= '0;
      dest_port           <= '0;
      payload_len         <= '0;
      remaining           <= '0;
      hdr_idx             <= '0;
      last_loaded         <= 1'b0;
      drain_seen          <= 1'b0;
      udp_axis_tdata_out  <= '0;
      udp_axis_tvalid_out <= 1'b0;
      udp_axis_tlast_out  <= 1'b0;
      len_err_out         <= 1'b0;
    end else begin
      len_err_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hdr_accept) begin
            if (len_bad) begin
              len_err_out <= 1'b1;
            end else begin
              src_port            <= src_port_in;
              dest_port           <= dest_port_in;
              payload_len         <= payload_len_in;
              remaining           <= payload_len_in;
              hdr_idx             <= 3'd0;
              udp_axis_tdata_out  <= src_port_in[15:8];
              udp_axis_tvalid_out <= 1'b1;
              udp_axis_tlast_out  <= 1'b0;
              state               <= HDR;
            end
          end
        end
        HDR: begin
          if (out_fire) begin
            if (hdr_idx == 3'd7) begin
              udp_axis_tvalid_out <= 1'b0;
              state               <= PAYLOAD;
            end else begin
              hdr_idx            <= hdr_idx + 3'd1;
              udp_axis_tdata_out <= hdr_byte(hdr_idx + 3'd1);
            end
          end
        end
        PAYLOAD: begin
          if (in_fire) begin
            udp_axis_tdata_out  <= udpdata_tdata_in;
            udp_axis_tvalid_out <= 1'b1;
            remaining           <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              udp_axis_tlast_out <= 1'b1;
              if (udpdata_tlast_in) begin
                last_loaded <= 1'b1;
              end else begin
                len_err_out <= 1'b1;
                state       <= DRAIN;
              end
            end else if (udpdata_tlast_in) begin
              udp_axis_tlast_out <= 1'b1;
              last_loaded        <= 1'b1;
              len_err_out        <= 1'b1;
            end else begin
              udp_axis_tlast_out <= 1'b0;
            end
          end else if (out_fire) begin
            udp_axis_tvalid_out <= 1'b0;
            udp_axis_tlast_out  <= 1'b0;
            if (last_loaded) begin
              last_loaded <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            udp_axis_tvalid_out <= 1'b0;
            udp_axis_tlast_out  <= 1'b0;
          end
          // leave only once the input tail is gone and the last byte is out
          if (drain_end && (!udp_axis_tvalid_out || out_fire)) begin
            drain_seen <= 1'b0;
            state      <= IDLE;
          end else if (in_fire && udpdata_tlast_in) begin
            drain_seen <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/udp_send.md
UDP_SEND -- requirements
Module: udp_send

Interface
REQ-001 Parameter MAX_PAYLOAD, default 1472, sets the largest accepted payload length in bytes.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 hdr_valid_in  input  1  header request valid.
REQ-005 hdr_ready_out  output  1  header request accepted when high together with hdr_valid_in.
REQ-006 src_port_in  input  16  UDP source port, sampled on header accept.
REQ-007 dest_port_in  input  16  UDP destination port, sampled on header accept.
REQ-008 payload_len_in  input  16  payload byte count, sampled on header accept.
REQ-009 udpdata_tdata_in / udpdata_tvalid_in / udpdata_tlast_in  input  8/1/1  application payload AXI-Stream.
REQ-010 udpdata_tready_out  output  1  payload stream ready.
REQ-011 udp_axis_tdata_out / udp_axis_tvalid_out / udp_axis_tlast_out  output  8/1/1  UDP datagram stream toward the IP layer.
REQ-012 udp_axis_tready_in  input  1  downstream ready.
REQ-013 len_err_out  output  1  one-cycle pulse on any length error.
REQ-014 busy_out  output  1  high in any state other than IDLE.

Function
REQ-015 States are IDLE, HDR, PAYLOAD and DRAIN.
REQ-016 hdr_ready_out shall be high only in IDLE.
REQ-017 On header accept with 1 <= payload_len_in <= MAX_PAYLOAD, the block shall latch the three fields, load header byte 0 into the output register and enter HDR, so that tvalid is high in the next cycle.
REQ-018 On header accept with payload_len_in = 0 or payload_len_in > MAX_PAYLOAD, the block shall pulse len_err_out, emit nothing and remain in IDLE.
REQ-019 The header bytes, MSB first, shall be src_port[15:8], src_port[7:0], dest_port[15:8], dest_port[7:0], length[15:8], length[7:0], 0x00, 0x00.
REQ-020 length shall equal payload_len + 8, computed in 16 bits.
REQ-021 The checksum field shall always be 0x0000 (checksum disabled).
REQ-022 The output register shall follow AXI rules: once tvalid is high, tdata and tlast shall hold until tvalid and tready are both high; tvalid shall never drop without a transfer.
REQ-023 The output register shall advance one header byte per transfer.
REQ-024 Transfer of header byte 7 shall move the state to PAYLOAD.
REQ-025 In PAYLOAD, udpdata_tready_out shall equal (not udp_axis_tvalid_out) or udp_axis_tready_in.
REQ-026 In all other states except DRAIN, udpdata_tready_out shall be low.
REQ-027 Each accepted payload byte shall load the output register at the same edge and decrement a 16-bit remaining counter.
REQ-028 Input-to-output latency is 1 cycle.
REQ-029 Sustained throughput is 1 byte per cycle with no bubbles while ready.
REQ-030 Normal end: when the counter reaches the last byte and udpdata_tlast_in is high, the block shall output that byte with tlast=1 and return to IDLE after it transfers.
REQ-031 Early tlast: when udpdata_tlast_in arrives before the counted last byte, the block shall output that byte with tlast=1 and pulse len_err_out, and return to IDLE after the transfer.
REQ-032 Missing tlast: when the counted last byte arrives without udpdata_tlast_in, the block shall output it with tlast=1, pulse len_err_out and enter DRAIN.
REQ-033 In DRAIN, udpdata_tready_out shall be 1 and input bytes shall be discarded.
REQ-034 DRAIN shall exit to IDLE on the cycle after an input byte with tlast is accepted.
REQ-035 udp_axis_tlast_out shall be high only on the final datagram byte.
REQ-036 A new header shall not be accepted until the final datagram byte has transferred.

Reset
REQ-037 Asserting reset at any time, including mid-datagram, shall force the IDLE state.
REQ-038 Reset shall force all outputs to 0 except hdr_ready_out, which shall be 1.
REQ-039 Reset shall clear the latched fields and the counter to 0.
REQ-040 A partial datagram interrupted by reset shall not resume after reset deasserts.

Verification
REQ-041 Test 1: header src=0x1234, dst=0x5678, len=4; payload AA BB CC DD with tlast on DD; tready held at 1. Required response: output 12 34 56 78 00 0C 00 00 AA BB CC DD, tlast on DD only, len_err never asserted.
REQ-042 Test 2: the same as test 1 with udp_axis_tready_in toggled pseudo-randomly. Required response: identical byte sequence, no dropped or duplicated bytes, and tdata stable while stalled.
REQ-043 Test 3: len=4 with tlast on the 2nd payload byte. Required response: 10 bytes output with tlast on the 10th, one len_err pulse, return to IDLE.
REQ-044 Test 4: len=2 with 5 payload bytes and tlast on the 5th. Required response: 10 bytes output, one len_err pulse, 3 bytes discarded in DRAIN, hdr_ready_out high afterward.
REQ-045 Test 5: header len=0, then a header with len=1473. Required response: two len_err pulses, no output, hdr_ready_out remains 1.
REQ-046 Test 6: reset asserted during header byte 3. Required response: tvalid goes to 0 immediately; after release, a new len=1 datagram emits 9 correct bytes.
